// File: rtl/pe_pkg.sv
// Shared definitions for the PE command interface: command codes, accumulate
// modes, the conv-sequencer state type and a small elaboration helper.
package pe_pkg;

  localparam int unsigned RESET            = 0;
  localparam int unsigned TRIGGER          = 1;
  localparam int unsigned TRIGGER_LAST     = 2;
  localparam int unsigned SET_MUL_VAL      = 3;
  localparam int unsigned SET_ADD_VAL      = 4;
  localparam int unsigned LOAD_DATA        = 5;
  localparam int unsigned SET_CONV_MODE    = 6;
  localparam int unsigned SET_FIX_MAC_MODE = 7;
  localparam int unsigned FORWARD          = 8;

  localparam int unsigned MODE_MAC     = 0;
  localparam int unsigned MODE_CONV    = 1;
  localparam int unsigned MODE_FIX_MAC = 2;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    CFG,
    STREAM,
    SETTLE,
    WAIT,
    RESP
  } seq_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pe_conv_seq.sv
// Convolution job sequencer feeding one GeMM PE: clears and configures the PE, streams
// N operand pairs as TRIGGERs, waits for the accumulator and returns its value.
// Build option PE_SEQ_TIMEOUT_EN bounds WAIT to TIMEOUT_CYC cycles and flags res_timeout.
//
// state  | meaning
// IDLE   | ready for a job
// CLR    | PE RESET command
// CFG    | PE SET_CONV_MODE with the job length
// STREAM | one TRIGGER per accepted operand beat
// SETTLE | guard cycles before pe_busy is trusted
// WAIT   | wait for pe_busy to fall, capture the MAC value
// RESP   | hold the result until res_ready
module pe_conv_seq
  import pe_pkg::*;
#(
  parameter int unsigned ACLEN       = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned SETTLE_CYC  = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [LEN_W-1:0]      job_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0] in_weight,
  output logic                  pe_cmd_valid,
  output logic [ACLEN:0]        pe_cmd,
  output logic [DATA_WIDTH-1:0] pe_param_1,
  output logic [DATA_WIDTH-1:0] pe_param_2,
  output logic [DATA_WIDTH-1:0] pe_data,
  output logic [DATA_WIDTH-1:0] pe_weight,
  input  logic                  pe_busy,
  input  logic [DATA_WIDTH-1:0] pe_mac_value,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_timeout,
  output logic                  idle
);

  localparam int unsigned CW    = ACLEN + 1;
  localparam int unsigned TMR_W = $clog2(max_u(SETTLE_CYC, TIMEOUT_CYC) + 1);

  // SETTLE always lasts at least one cycle, even with SETTLE_CYC = 0.
  localparam logic [TMR_W-1:0] SETTLE_LOAD  = TMR_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  seq_state_t state, state_nxt;

  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      beat_cnt;
  logic [TMR_W-1:0]      tmr;
  logic [DATA_WIDTH-1:0] res_data_q;

  logic job_acc;
  logic beat_acc;
  logic last_beat;
  logic tmr_done;
  logic timed_out;
  logic wait_done;

  assign job_acc   = job_valid && (state == IDLE);
  assign beat_acc  = in_valid && (state == STREAM);
  assign last_beat = (beat_cnt == (len_q - LEN_W'(1)));
  assign tmr_done  = (tmr == '0);
  assign wait_done = !pe_busy || timed_out;

`ifdef PE_SEQ_TIMEOUT_EN
  assign timed_out = tmr_done;
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (job_acc) state_nxt = CLR;
      CLR:     state_nxt = (len_q != '0) ? CFG : RESP;
      CFG:     state_nxt = STREAM;
      STREAM:  if (beat_acc && last_beat) state_nxt = SETTLE;
      SETTLE:  if (tmr_done) state_nxt = WAIT;
      WAIT:    if (wait_done) state_nxt = RESP;
      RESP:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    job_ready    = (state == IDLE);
    in_ready     = (state == STREAM);
    res_valid    = (state == RESP);
    idle         = (state == IDLE);
    pe_cmd_valid = 1'b0;
    pe_cmd       = '0;
    pe_param_1   = '0;
    pe_param_2   = '0;
    pe_data      = '0;
    pe_weight    = '0;
    case (state)
      CLR: begin
        pe_cmd_valid = 1'b1;
        pe_cmd       = CW'(RESET);
      end
      CFG: begin
        pe_cmd_valid = 1'b1;
        pe_cmd       = CW'(SET_CONV_MODE);
        pe_param_1   = DATA_WIDTH'(len_q);
      end
      STREAM: begin
        if (in_valid) begin
          pe_cmd_valid = 1'b1;
          pe_cmd       = CW'(TRIGGER);
          pe_data      = in_data;
          pe_weight    = in_weight;
        end
      end
      default: ;
    endcase
  end

  // One down-counter serves both the settle guard and the WAIT bound.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      len_q      <= '0;
      beat_cnt   <= '0;
      tmr        <= '0;
      res_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (job_acc) begin
            len_q    <= job_len;
            beat_cnt <= '0;
          end
        end
        CLR: begin
          if (len_q == '0) res_data_q <= '0;
        end
        STREAM: begin
          if (beat_acc) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (last_beat) tmr <= SETTLE_LOAD;
          end
        end
        SETTLE: begin
          tmr <= tmr_done ? TIMEOUT_LOAD : (tmr - TMR_W'(1));
        end
        WAIT: begin
          if (wait_done) begin
            res_data_q <= pe_mac_value;
          end else if (!tmr_done) begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign res_data = res_data_q;

`ifdef PE_SEQ_TIMEOUT_EN
  logic res_timeout_q;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      res_timeout_q <= 1'b0;
    end else if ((state == WAIT) && wait_done) begin
      res_timeout_q <= pe_busy;
    end else if ((state == RESP) && res_ready) begin
      res_timeout_q <= 1'b0;
    end
  end

  assign res_timeout = res_timeout_q;
`else
  assign res_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pe_conv_seq.sv
// Directed/randomized bench for pe_conv_seq with a behavioural PE model and an
// expected command list built from each job's length and accepted operand beats.
module tb_pe_conv_seq;
  import pe_pkg::*;

  localparam int unsigned ACLEN   = 4;
  localparam int unsigned DW      = 32;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned SETTLE  = 2;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CW      = ACLEN + 1;

  typedef struct packed {
    logic [ACLEN:0] cmd;
    logic [DW-1:0]  p1;
    logic [DW-1:0]  p2;
    logic [DW-1:0]  d;
    logic [DW-1:0]  w;
  } cmd_t;

  logic             clk_i = 1'b0;
  logic             rst;
  logic             job_valid;
  logic             job_ready;
  logic [LEN_W-1:0] job_len;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic [DW-1:0]    in_weight;
  logic             pe_cmd_valid;
  logic [ACLEN:0]   pe_cmd;
  logic [DW-1:0]    pe_param_1;
  logic [DW-1:0]    pe_param_2;
  logic [DW-1:0]    pe_data;
  logic [DW-1:0]    pe_weight;
  logic             pe_busy;
  logic [DW-1:0]    pe_mac_value;
  logic             res_valid;
  logic             res_ready;
  logic [DW-1:0]    res_data;
  logic             res_timeout;
  logic             idle;

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  cmd_t log_q[$];
  cmd_t exp_q[$];

  // PE model: busy from each TRIGGER until busy_hold cycles after the latest one,
  // garbage accumulator while busy, pe_final once it goes idle.
  logic          pe_busy_r = 1'b0;
  int            pe_hold   = 0;
  logic [DW-1:0] pe_mac_q  = '0;
  int            busy_hold = 4;
  logic [DW-1:0] pe_final  = '0;
  bit            pe_stuck  = 1'b0;

  assign pe_busy      = pe_busy_r | pe_stuck;
  assign pe_mac_value = pe_mac_q;

  pe_conv_seq #(
    .ACLEN(ACLEN), .DATA_WIDTH(DW), .LEN_W(LEN_W),
    .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
    .pe_cmd_valid(pe_cmd_valid), .pe_cmd(pe_cmd), .pe_param_1(pe_param_1),
    .pe_param_2(pe_param_2), .pe_data(pe_data), .pe_weight(pe_weight),
    .pe_busy(pe_busy), .pe_mac_value(pe_mac_value),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_timeout(res_timeout), .idle(idle)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (pe_cmd_valid && pe_cmd == CW'(TRIGGER)) begin
      pe_busy_r <= 1'b1;
      pe_hold   <= busy_hold;
      pe_mac_q  <= $urandom;
    end else if (pe_stuck) begin
      pe_busy_r <= 1'b1;
      pe_hold   <= 0;
      pe_mac_q  <= $urandom;
    end else if (pe_busy_r) begin
      if (pe_hold == 0) begin
        pe_busy_r <= 1'b0;
        pe_mac_q  <= pe_final;
      end else begin
        pe_hold  <= pe_hold - 1;
        pe_mac_q <= $urandom;
      end
    end
  end

  always @(negedge clk_i) begin
    cmd_t e;
    if (mon_en) begin
      if (pe_cmd_valid) begin
        e.cmd = pe_cmd;
        e.p1  = pe_param_1;
        e.p2  = pe_param_2;
        e.d   = (pe_cmd == CW'(TRIGGER)) ? pe_data : '0;
        e.w   = (pe_cmd == CW'(TRIGGER)) ? pe_weight : '0;
        log_q.push_back(e);
      end else begin
        n_cmp++;
        assert ({pe_cmd, pe_param_1, pe_param_2} === '0)
        else begin
          n_fail++;
          $error("FAIL idle_cmd_zero: observed cmd=%0h p1=%0h p2=%0h expected all 0",
                 pe_cmd, pe_param_1, pe_param_2);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish by 400000 expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_cmd_count"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      n_cmp++;
      assert (log_q[i] === exp_q[i])
      else begin
        n_fail++;
        $error("FAIL %s_cmd[%0d]: observed %h expected %h", tag, i, log_q[i], exp_q[i]);
      end
    end
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_res(input int limit, inout int n, output bit got,
                          inout logic [DW-1:0] last_mac);
    got = 1'b0;
    while (n < limit) begin
      @(negedge clk_i);
      if (res_valid) begin
        got = 1'b1;
        break;
      end
      last_mac = pe_mac_value;
      tick();
      n++;
    end
  endtask

  task automatic push_cmd(input int unsigned code, input logic [DW-1:0] p1,
                          input logic [DW-1:0] d, input logic [DW-1:0] w);
    cmd_t e;
    e.cmd = CW'(code);
    e.p1  = p1;
    e.p2  = '0;
    e.d   = d;
    e.w   = w;
    exp_q.push_back(e);
  endtask

  // mode: 0 = back-to-back beats, 1 = alternating bubbles, 2 = random bubbles
  task automatic run_job(input int len, input int mode, input int res_delay, input int hold,
                         input logic [DW-1:0] mac, input int abort_after, input bit stuck);
    int            cyc;
    int            acc;
    int            n;
    bit            phase;
    bit            got;
    logic [DW-1:0] d;
    logic [DW-1:0] w;
    logic [DW-1:0] last_mac;
    logic [DW-1:0] exp_res;
    logic          exp_to;

    tick();
    busy_hold = hold;
    pe_final  = mac;
    job_len   = LEN_W'(len);
    job_valid = 1'b1;
    cyc = 0;
    @(negedge clk_i);
    while (!job_ready && cyc < 50) begin
      tick();
      @(negedge clk_i);
      cyc++;
    end
    check("job_accept", job_ready, 1);
    tick();
    job_valid = 1'b0;
    job_len   = LEN_W'($urandom);
    pe_stuck  = stuck;

    push_cmd(RESET, '0, '0, '0);
    if (len > 0) push_cmd(SET_CONV_MODE, DW'(len), '0, '0);

    n = 0;
    last_mac = '0;
    exp_to = 1'b0;
    if (len == 0) begin
      wait_res(50, n, got, last_mac);
      check("len0_latency_le2", 64'(n <= 2), 1);
      exp_res = '0;
    end else begin
      acc = 0;
      cyc = 0;
      phase = 1'b0;
      d = $urandom;
      w = $urandom;
      while (acc < len && cyc < 4 * len + 50) begin
        case (mode)
          0:       in_valid = 1'b1;
          1:       in_valid = !phase;
          default: in_valid = 1'($urandom_range(0, 1));
        endcase
        phase = !phase;
        in_data   = d;
        in_weight = w;
        @(negedge clk_i);
        if (in_valid && in_ready) begin
          push_cmd(TRIGGER, '0, d, w);
          acc++;
          d = $urandom;
          w = $urandom;
        end
        tick();
        cyc++;
        if (abort_after >= 0 && acc == abort_after) break;
      end
      check("beats_accepted", 64'(acc), 64'((abort_after >= 0) ? abort_after : len));

      if (abort_after >= 0) begin
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk_i);
        tick();
        rst = 1'b0;
        @(negedge clk_i);
        check("abort_idle", idle, 1);
        check("abort_cmd_valid", pe_cmd_valid, 0);
        check("abort_res_valid", res_valid, 0);
        check("abort_in_ready", in_ready, 0);
        compare_log("abort");
        return;
      end

      in_valid  = 1'b1;
      in_data   = $urandom;
      in_weight = $urandom;
      @(negedge clk_i);
      check("extra_beat_in_ready", in_ready, 0);
      check("extra_beat_cmd_valid", pe_cmd_valid, 0);
      tick();
      in_valid = 1'b0;
      n = 1;
      wait_res(stuck ? 100 : 300, n, got, last_mac);
`ifdef PE_SEQ_TIMEOUT_EN
      exp_to = stuck;
      if (stuck) check("timeout_latency", 64'(n), 64'(SETTLE + TIMEOUT));
      exp_res = stuck ? last_mac : mac;
`else
      if (stuck) begin
        check("stuck_no_result", got, 0);
        pe_stuck = 1'b0;
        wait_res(n + 100, n, got, last_mac);
      end
      exp_res = mac;
`endif
    end

    check("res_arrived", got, 1);
    if (!got) begin
      pe_stuck = 1'b0;
      log_q.delete();
      exp_q.delete();
      return;
    end
    check("res_data", res_data, exp_res);
    check("res_timeout", res_timeout, exp_to);

    for (int i = 0; i < res_delay; i++) begin
      tick();
      job_valid = 1'b1;
      job_len   = LEN_W'($urandom_range(1, 5));
      @(negedge clk_i);
      check("hold_res_valid", res_valid, 1);
      check("hold_res_data", res_data, exp_res);
      check("hold_job_ready", job_ready, 0);
      check("hold_idle", idle, 0);
    end
    res_ready = 1'b1;
    check("hs_job_ready", job_ready, 0);
    tick();
    res_ready = 1'b0;
    job_valid = 1'b0;
    @(negedge clk_i);
    check("post_hs_job_ready", job_ready, 1);
    check("post_hs_res_valid", res_valid, 0);
    check("post_hs_res_timeout", res_timeout, 0);
    compare_log("job");
  endtask

  initial begin
    rst       = 1'b1;
    job_valid = 1'b0;
    job_len   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_weight = '0;
    res_ready = 1'b0;
    tick();
    tick();
    @(negedge clk_i);
    check("rst_job_ready", job_ready, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_cmd_valid", pe_cmd_valid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_timeout", res_timeout, 0);
    check("rst_idle", idle, 1);
    mon_en = 1'b1;
    tick();
    rst = 1'b0;

    run_job(3, 0, 0, 4, 32'h4040_0000, -1, 1'b0);
    run_job(4, 1, 0, 4, $urandom, -1, 1'b0);
    run_job(0, 0, 0, 4, $urandom | 32'h1, -1, 1'b0);
    run_job($urandom_range(5, 12), 2, 10, 3, $urandom, -1, 1'b0);
    run_job(5, 0, 0, 6, $urandom, 2, 1'b0);
    run_job(2, 0, 0, 4, $urandom, -1, 1'b0);
    for (int j = 0; j < 5; j++) begin
      run_job($urandom_range(1, 12), $urandom_range(0, 2), $urandom_range(0, 3),
              $urandom_range(0, 6), $urandom, -1, 1'b0);
    end
    run_job(3, 0, 2, 4, $urandom, -1, 1'b1);
    run_job(1, 0, 0, 2, $urandom, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
